// File: rtl/iec_sd_arbiter.sv
// iec_sd_arbiter: round-robin merge of per-drive SD sector request channels onto one host SD block port.
// Latency: request seen in IDLE -> grant latched next edge -> sd_rd/sd_wr high on the edge after that.
// Backpressure: one transfer in flight; other drives hold their level requests until granted.
// Optional watchdog: define SD_ARB_TIMEOUT_EN to abort REQ/XFER after TIMEOUT cycles (sticky timeout_err).
module iec_sd_arbiter #(
  parameter int          DRIVES  = 2,
  parameter logic [23:0] TIMEOUT = 24'hFFFFFF,
  localparam int         NDR     = (DRIVES < 1) ? 1 : ((DRIVES > 4) ? 4 : DRIVES)
) (
  input  logic           clk_sys,
  input  logic           reset,
  input  logic [31:0]    drv_lba      [NDR],
  input  logic [5:0]     drv_blk_cnt  [NDR],
  input  logic [NDR-1:0] drv_rd,
  input  logic [NDR-1:0] drv_wr,
  input  logic [7:0]     drv_buff_din [NDR],
  output logic [NDR-1:0] drv_ack,
  output logic [NDR-1:0] drv_buff_wr,
  output logic [31:0]    sd_lba,
  output logic [5:0]     sd_blk_cnt,
  output logic           sd_rd,
  output logic           sd_wr,
  input  logic           sd_ack,
  input  logic           sd_buff_wr,
  output logic [7:0]     sd_buff_din,
  output logic           busy,
  output logic [1:0]     grant,
  output logic           timeout_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    REL  = 2'd3
  } state_t;

  // Highest valid drive index; the round-robin pointer wraps against this, not against 3.
  localparam logic [1:0] LAST = 2'(NDR - 1);

  state_t           state, state_nxt;
  logic [1:0]       ptr, ptr_nxt;
  logic [1:0]       grant_nxt;
  logic [31:0]      lba_nxt;
  logic [5:0]       blk_nxt;
  logic             op_rd, op_rd_nxt;
  logic             sd_rd_nxt, sd_wr_nxt;
  logic [NDR-1:0]   ack_nxt;
  logic             rel_cnt, rel_nxt;
  logic             tmo_hit;

  // Per-drive inputs padded to four entries so a 2-bit index is always in range.
  logic [3:0]       req4;
  logic [3:0]       rd4;
  logic [31:0]      lba4 [4];
  logic [5:0]       blk4 [4];
  logic [7:0]       din4 [4];

  logic [1:0]       sel;
  logic             strobe_en;

  function automatic logic [1:0] wrap_inc(input logic [1:0] idx);
    return (idx == LAST) ? 2'd0 : idx + 2'd1;
  endfunction

  // Pad the per-drive channels; absent drives read as idle.
  always_comb begin
    req4 = '0;
    rd4  = '0;
    for (int i = 0; i < 4; i++) begin
      lba4[i] = '0;
      blk4[i] = '0;
      din4[i] = '0;
    end
    for (int i = 0; i < NDR; i++) begin
      req4[i] = drv_rd[i] | drv_wr[i];
      rd4[i]  = drv_rd[i];
      lba4[i] = drv_lba[i];
      blk4[i] = drv_blk_cnt[i];
      din4[i] = drv_buff_din[i];
    end
  end

  // Round-robin pick: first requesting drive at or after ptr, wrapping at LAST.
  always_comb begin
    logic [1:0] idx;
    logic       found;
    sel   = '0;
    found = 1'b0;
    idx   = ptr;
    for (int k = 0; k < NDR; k++) begin
      if (!found && req4[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
      idx = wrap_inc(idx);
    end
  end

  // Next-state and next-register values for the arbiter FSM.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    grant_nxt = grant;
    lba_nxt   = sd_lba;
    blk_nxt   = sd_blk_cnt;
    op_rd_nxt = op_rd;
    sd_rd_nxt = 1'b0;
    sd_wr_nxt = 1'b0;
    ack_nxt   = '0;
    rel_nxt   = 1'b0;

    case (state)
      IDLE: begin
        // sd_ack is deliberately ignored here: nothing is granted.
        if (|req4) begin
          grant_nxt = sel;
          lba_nxt   = lba4[sel];
          blk_nxt   = blk4[sel];
          op_rd_nxt = rd4[sel];
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (!req4[grant]) begin
          // Drive withdrew before the host answered: abort without moving ptr.
          state_nxt = IDLE;
        end else if (sd_ack) begin
          for (int i = 0; i < NDR; i++) begin
            if (grant == 2'(i)) ack_nxt[i] = 1'b1;
          end
          state_nxt = XFER;
        end else begin
          sd_rd_nxt = op_rd;
          sd_wr_nxt = ~op_rd;
        end
      end
      XFER: begin
        if (sd_ack) begin
          for (int i = 0; i < NDR; i++) begin
            if (grant == 2'(i)) ack_nxt[i] = 1'b1;
          end
        end else begin
          state_nxt = REL;
        end
      end
      REL: begin
        // A drive still requesting after two cycles is treated as a fresh request
        // and must compete again behind the other drives.
        if (!req4[grant] || rel_cnt) begin
          ptr_nxt   = wrap_inc(grant);
          state_nxt = IDLE;
        end else begin
          rel_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (tmo_hit) begin
      state_nxt = IDLE;
      sd_rd_nxt = 1'b0;
      sd_wr_nxt = 1'b0;
      ack_nxt   = '0;
      ptr_nxt   = wrap_inc(grant);
    end
  end

  // State register and registered host/drive outputs.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= '0;
      grant      <= '0;
      sd_lba     <= '0;
      sd_blk_cnt <= '0;
      op_rd      <= 1'b0;
      sd_rd      <= 1'b0;
      sd_wr      <= 1'b0;
      drv_ack    <= '0;
      rel_cnt    <= 1'b0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      grant      <= grant_nxt;
      sd_lba     <= lba_nxt;
      sd_blk_cnt <= blk_nxt;
      op_rd      <= op_rd_nxt;
      sd_rd      <= sd_rd_nxt;
      sd_wr      <= sd_wr_nxt;
      drv_ack    <= ack_nxt;
      rel_cnt    <= rel_nxt;
    end
  end

`ifdef SD_ARB_TIMEOUT_EN
  logic [23:0] tmo_cnt;
  logic        tmo_err;

  // Watchdog fires once the current REQ/XFER residency reaches TIMEOUT cycles.
  always_comb begin
    tmo_hit = ((state == REQ) || (state == XFER)) && (tmo_cnt == TIMEOUT - 24'd1);
  end

  // Watchdog counter restarts on entry to REQ or XFER; sticky error flag.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
      tmo_err <= 1'b0;
    end else begin
      if ((state_nxt != state) && ((state_nxt == REQ) || (state_nxt == XFER))) begin
        tmo_cnt <= '0;
      end else if ((state == REQ) || (state == XFER)) begin
        tmo_cnt <= tmo_cnt + 24'd1;
      end else begin
        tmo_cnt <= '0;
      end
      if (tmo_hit) tmo_err <= 1'b1;
    end
  end

  assign timeout_err = tmo_err;
`else
  logic tmo_unused;
  assign tmo_unused  = ^TIMEOUT;
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Buffer strobes pass only while the host is acking the granted drive.
  always_comb begin
    strobe_en   = (state == XFER) || ((state == REQ) && sd_ack && req4[grant]);
    drv_buff_wr = '0;
    for (int i = 0; i < NDR; i++) begin
      if (grant == 2'(i)) drv_buff_wr[i] = strobe_en & sd_buff_wr;
    end
  end

  assign sd_buff_din = din4[grant];
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_iec_sd_arbiter.sv
// Bench for iec_sd_arbiter with four drives: reset, latency, rd/wr routing, abort,
// round-robin fairness, asynchronous reset mid-transfer and (when SD_ARB_TIMEOUT_EN) the watchdog.
module tb_iec_sd_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [31:0] drv_lba      [4];
  logic [5:0]  drv_blk_cnt  [4];
  logic [3:0]  drv_rd, drv_wr;
  logic [7:0]  drv_buff_din [4];
  logic [3:0]  drv_ack, drv_buff_wr;
  logic [31:0] sd_lba;
  logic [5:0]  sd_blk_cnt;
  logic        sd_rd, sd_wr, sd_ack, sd_buff_wr;
  logic [7:0]  sd_buff_din;
  logic        busy;
  logic [1:0]  grant;
  logic        timeout_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]  g;
    logic [31:0] lba;
    logic [5:0]  blk;
    logic        rd;
  } exp_t;

  exp_t exp_q[$];
  int   strobe_cnt [4];

  always #5 clk_sys = ~clk_sys;

  iec_sd_arbiter #(.DRIVES(4), .TIMEOUT(24'd100)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .drv_lba      (drv_lba),
    .drv_blk_cnt  (drv_blk_cnt),
    .drv_rd       (drv_rd),
    .drv_wr       (drv_wr),
    .drv_buff_din (drv_buff_din),
    .drv_ack      (drv_ack),
    .drv_buff_wr  (drv_buff_wr),
    .sd_lba       (sd_lba),
    .sd_blk_cnt   (sd_blk_cnt),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .sd_buff_wr   (sd_buff_wr),
    .sd_buff_din  (sd_buff_din),
    .busy         (busy),
    .grant        (grant),
    .timeout_err  (timeout_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected host request for drive g, taken from the stimulus at request time.
  task automatic push_exp(input logic [1:0] g);
    exp_t e;
    e.g   = g;
    e.lba = drv_lba[g];
    e.blk = drv_blk_cnt[g];
    e.rd  = drv_rd[g];
    exp_q.push_back(e);
  endtask

  // Host model: wait for a request, compare it against the scoreboard, ack, strobe, release.
  task automatic serve(input int ack_delay, input int nstrobe, input bit release_req);
    exp_t e;
    int   wait_cyc;
    int   din_bad;
    int   others;
    wait_cyc = 0;
    while (!(sd_rd || sd_wr) && wait_cyc < 60) begin
      @(negedge clk_sys);
      wait_cyc++;
    end
    chk("req_seen", 64'(sd_rd | sd_wr), 1);
    chk("sb_has_entry", 64'(exp_q.size() > 0), 1);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else begin
      e.g = '0; e.lba = '0; e.blk = '0; e.rd = 1'b0;
    end
    chk("grant", grant, e.g);
    chk("sd_lba", sd_lba, e.lba);
    chk("sd_blk_cnt", sd_blk_cnt, e.blk);
    chk("sd_rd_op", sd_rd, e.rd);
    chk("sd_wr_op", sd_wr, !e.rd);
    repeat (ack_delay) @(negedge clk_sys);
    sd_ack = 1'b1;
    @(negedge clk_sys);
    chk("drv_ack_hi", drv_ack, 4'b0001 << e.g);
    chk("sd_req_drop", 64'(sd_rd | sd_wr), 0);
    if (release_req) begin
      drv_rd[e.g] = 1'b0;
      drv_wr[e.g] = 1'b0;
    end
    din_bad    = 0;
    strobe_cnt = '{default: 0};
    for (int n = 0; n < nstrobe; n++) begin
      drv_buff_din[e.g] = 8'(n * 7 + 1);
      sd_buff_wr = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) if (drv_buff_wr[i]) strobe_cnt[i]++;
      if (sd_buff_din !== drv_buff_din[e.g]) din_bad++;
      @(negedge clk_sys);
      sd_buff_wr = 1'b0;
      @(negedge clk_sys);
    end
    sd_ack = 1'b0;
    @(negedge clk_sys);
    chk("drv_ack_lo", drv_ack, 0);
    if (nstrobe > 0) begin
      others = 0;
      for (int i = 0; i < 4; i++) if (i != int'(e.g)) others += strobe_cnt[i];
      chk("buff_wr_granted", strobe_cnt[e.g], nstrobe);
      chk("buff_wr_others", others, 0);
      chk("buff_din_mux", din_bad, 0);
    end
  endtask

  initial begin
    int cyc;
    reset      = 1'b1;
    sd_ack     = 1'b0;
    sd_buff_wr = 1'b0;
    drv_rd     = '0;
    drv_wr     = '0;
    for (int i = 0; i < 4; i++) begin
      drv_lba[i]      = '0;
      drv_blk_cnt[i]  = '0;
      drv_buff_din[i] = '0;
    end
    repeat (3) @(negedge clk_sys);

    // Reset values
    chk("rst_sd_rd", sd_rd, 0);
    chk("rst_sd_wr", sd_wr, 0);
    chk("rst_drv_ack", drv_ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_sd_lba", sd_lba, 0);
    chk("rst_sd_blk_cnt", sd_blk_cnt, 0);
    chk("rst_timeout_err", timeout_err, 0);
    reset = 1'b0;
    @(negedge clk_sys);

    // Host ack while idle is ignored
    sd_ack = 1'b1;
    repeat (3) @(negedge clk_sys);
    chk("idle_ack_ignored", drv_ack, 0);
    chk("idle_ack_busy", busy, 0);
    sd_ack = 1'b0;
    @(negedge clk_sys);

    // Single read from drive 0: two-edge latency, latched address
    drv_lba[0]     = 32'd5;
    drv_blk_cnt[0] = 6'd3;
    drv_rd[0]      = 1'b1;
    push_exp(2'd0);
    @(negedge clk_sys);
    chk("lat_edge1_sd_rd", sd_rd, 0);
    chk("lat_edge1_busy", busy, 1);
    @(negedge clk_sys);
    chk("lat_edge2_sd_rd", sd_rd, 1);
    drv_lba[0]     = 32'd77;
    drv_blk_cnt[0] = 6'd9;
    serve(2, 0, 1'b1);
    repeat (4) @(negedge clk_sys);
    chk("t1_back_idle", busy, 0);

    // Write from drive 1 with 512 buffer strobes
    drv_lba[1]     = 32'h1234;
    drv_blk_cnt[1] = 6'd7;
    drv_wr[1]      = 1'b1;
    push_exp(2'd1);
    serve(1, 512, 1'b1);
    repeat (4) @(negedge clk_sys);

    // Request dropped while in REQ: abort, no ack, pointer untouched
    drv_lba[0] = 32'd9;
    drv_rd[0]  = 1'b1;
    @(negedge clk_sys);
    @(negedge clk_sys);
    chk("abort_sd_rd_up", sd_rd, 1);
    chk("abort_grant", grant, 0);
    drv_rd[0] = 1'b0;
    @(negedge clk_sys);
    chk("abort_sd_rd_drop", sd_rd, 0);
    chk("abort_idle", busy, 0);
    chk("abort_no_ack", drv_ack, 0);
    @(negedge clk_sys);
    chk("abort_stays_idle", busy, 0);

    // Pointer still at 2: drives 1 and 3 requesting -> 3 first, then 1 (rd wins over wr)
    drv_lba[1]     = 32'd111;
    drv_blk_cnt[1] = 6'd11;
    drv_rd[1]      = 1'b1;
    drv_wr[1]      = 1'b1;
    drv_lba[3]     = 32'd333;
    drv_blk_cnt[3] = 6'd33;
    drv_rd[3]      = 1'b1;
    push_exp(2'd3);
    push_exp(2'd1);
    serve(3, 0, 1'b1);
    serve(3, 0, 1'b1);
    repeat (4) @(negedge clk_sys);

    // Asynchronous reset in the middle of a transfer
    drv_lba[2] = 32'hCAFE;
    drv_rd[2]  = 1'b1;
    cyc = 0;
    while (!sd_rd && cyc < 20) begin
      @(negedge clk_sys);
      cyc++;
    end
    chk("t6_sd_rd", sd_rd, 1);
    chk("t6_grant", grant, 2);
    sd_ack = 1'b1;
    repeat (2) @(negedge clk_sys);
    chk("t6_ack_routed", drv_ack, 4'b0100);
    #3 reset = 1'b1;
    #1;
    chk("t6_async_ack", drv_ack, 0);
    chk("t6_async_busy", busy, 0);
    chk("t6_async_grant", grant, 0);
    chk("t6_async_lba", sd_lba, 0);
    drv_rd[2] = 1'b0;
    sd_ack    = 1'b0;
    @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);

    // All four drives requesting continuously: strict rotation 0,1,2,3,0
    for (int i = 0; i < 4; i++) begin
      drv_lba[i]     = 32'(100 + i);
      drv_blk_cnt[i] = 6'(i + 1);
    end
    drv_rd = 4'hF;
    push_exp(2'd0);
    push_exp(2'd1);
    push_exp(2'd2);
    push_exp(2'd3);
    push_exp(2'd0);
    for (int k = 0; k < 5; k++) serve(10, 0, 1'b0);
    drv_rd = '0;
    repeat (5) @(negedge clk_sys);
    chk("fair_back_idle", busy, 0);

`ifdef SD_ARB_TIMEOUT_EN
    // Watchdog: drive 1 never acked, drops near cycle 100, drive 2 granted next
    drv_rd[1] = 1'b1;
    drv_rd[2] = 1'b1;
    cyc = 0;
    while (!sd_rd && cyc < 20) begin
      @(negedge clk_sys);
      cyc++;
    end
    chk("tmo_first_grant", grant, 1);
    cyc = 0;
    while (sd_rd && cyc < 300) begin
      @(negedge clk_sys);
      cyc++;
    end
    chk("tmo_sd_rd_dropped", sd_rd, 0);
    chk("tmo_cycles_near_limit", 64'((cyc >= 95) && (cyc <= 105)), 1);
    chk("tmo_err_set", timeout_err, 1);
    cyc = 0;
    while (!sd_rd && cyc < 20) begin
      @(negedge clk_sys);
      cyc++;
    end
    chk("tmo_next_grant", grant, 2);
    drv_rd = '0;
    repeat (3) @(negedge clk_sys);
    reset = 1'b1;
    @(negedge clk_sys);
    chk("tmo_err_cleared", timeout_err, 0);
    reset = 1'b0;
    @(negedge clk_sys);
`else
    chk("timeout_err_tied", timeout_err, 0);
`endif

    chk("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound in case the DUT stalls somewhere unexpected.
  initial begin
    #2000000;
    $display("FAIL watchdog simulation time bound reached total=%0d bad=%0d", total, bad);
    $fatal(1, "time bound");
  end

endmodule
